// File: rtl/piton_dcr_noc_decoder.sv
// piton_dcr_noc_decoder: terminates NoC DCR-write requests, issues one buffer write and an ACK flit per request
module piton_dcr_noc_decoder #(
  parameter int VX_DCR_ADDR_WIDTH = 8,
  parameter int VX_DCR_DATA_WIDTH = 32,
  parameter int NOC_DATA_WIDTH = 64,
  parameter logic [7:0] MSG_TYPE_DCR_WR = 8'd35,
  parameter logic [7:0] MSG_TYPE_DCR_ACK = 8'd27
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         noc_in_val,
  input  logic [NOC_DATA_WIDTH-1:0]    noc_in_data,
  output logic                         noc_in_rdy,
  output logic                         noc_out_val,
  output logic [NOC_DATA_WIDTH-1:0]    noc_out_data,
  input  logic                         noc_out_rdy,
  output logic                         buffer_wr_valid,
  output logic [VX_DCR_ADDR_WIDTH-1:0] buffer_wr_addr,
  output logic [VX_DCR_DATA_WIDTH-1:0] buffer_wr_data,
  input  logic                         buffer_full,
  output logic [7:0]                   drop_count
);
  typedef enum logic [2:0] {HDR, SRC, PAY, WRITE, ACK, DRAIN} state_t;
  state_t state_q, state_d;
  logic [7:0] remaining_q, remaining_d, mshr_q, mshr_d, drop_q, drop_d;
  logic [7:0] src_x_q, src_x_d, src_y_q, src_y_d;
  logic [13:0] src_chip_q, src_chip_d;
  logic [VX_DCR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [VX_DCR_DATA_WIDTH-1:0] data_q, data_d;
  logic [7:0] hdr_len, hdr_type, drop_inc;
  assign hdr_len = noc_in_data[29:22];
  assign hdr_type = noc_in_data[21:14];
  assign drop_inc = (drop_q == 8'hff) ? drop_q : drop_q + 8'd1;
  assign noc_in_rdy = (state_q == HDR) || (state_q == SRC) || (state_q == PAY) || (state_q == DRAIN);
  assign noc_out_val = (state_q == ACK);
  assign buffer_wr_valid = (state_q == WRITE) && !buffer_full;
  assign buffer_wr_addr = addr_q;
  assign buffer_wr_data = data_q;
  assign drop_count = drop_q;
  assign noc_out_data = noc_out_val ? NOC_DATA_WIDTH'({src_chip_q, src_x_q, src_y_q, 4'd0, 8'd0, MSG_TYPE_DCR_ACK, mshr_q, 6'd0}) : '0;
  always_comb begin
    state_d = state_q;
    remaining_d = remaining_q;
    mshr_d = mshr_q;
    drop_d = drop_q;
    src_chip_d = src_chip_q;
    src_x_d = src_x_q;
    src_y_d = src_y_q;
    addr_d = addr_q;
    data_d = data_q;
    case (state_q)
      HDR: if (noc_in_val) begin
        mshr_d = noc_in_data[13:6];
        remaining_d = hdr_len;
        if (hdr_type == MSG_TYPE_DCR_WR && hdr_len == 8'd2) state_d = SRC;
        else begin
          drop_d = drop_inc;
          state_d = (hdr_len == 8'd0) ? HDR : DRAIN;
        end
      end
      SRC: if (noc_in_val) begin
        src_chip_d = noc_in_data[63:50];
        src_x_d = noc_in_data[49:42];
        src_y_d = noc_in_data[41:34];
        state_d = PAY;
      end
      PAY: if (noc_in_val) begin
        addr_d = noc_in_data[32 +: VX_DCR_ADDR_WIDTH];
        data_d = noc_in_data[VX_DCR_DATA_WIDTH-1:0];
        state_d = WRITE;
      end
      WRITE: state_d = buffer_full ? WRITE : ACK;
      ACK: state_d = noc_out_rdy ? HDR : ACK;
      DRAIN: if (noc_in_val) begin
        remaining_d = remaining_q - 8'd1;
        state_d = (remaining_q == 8'd1) ? HDR : DRAIN;
      end
      default: state_d = HDR;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HDR;
      remaining_q <= '0;
      mshr_q <= '0;
      drop_q <= '0;
      src_chip_q <= '0;
      src_x_q <= '0;
      src_y_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      remaining_q <= remaining_d;
      mshr_q <= mshr_d;
      drop_q <= drop_d;
      src_chip_q <= src_chip_d;
      src_x_q <= src_x_d;
      src_y_q <= src_y_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_piton_dcr_noc_decoder.sv
// tb_piton_dcr_noc_decoder: table-driven and directed checks of the DCR NoC decoder
module tb_piton_dcr_noc_decoder;
  logic clk = 0, rst = 1;
  logic noc_in_val = 0, noc_in_rdy, noc_out_val, noc_out_rdy = 1;
  logic [63:0] noc_in_data = '0, noc_out_data;
  logic buffer_wr_valid, buffer_full = 0;
  logic [7:0] buffer_wr_addr, drop_count;
  logic [31:0] buffer_wr_data;
  int n_checks = 0, n_fail = 0;
  int wr_cnt = 0, ack_cnt = 0, full_viol = 0;
  logic [7:0] last_addr = '0;
  logic [31:0] last_data = '0;
  logic [63:0] last_ack = '0;
  piton_dcr_noc_decoder dut (
    .clk(clk), .rst(rst),
    .noc_in_val(noc_in_val), .noc_in_data(noc_in_data), .noc_in_rdy(noc_in_rdy),
    .noc_out_val(noc_out_val), .noc_out_data(noc_out_data), .noc_out_rdy(noc_out_rdy),
    .buffer_wr_valid(buffer_wr_valid), .buffer_wr_addr(buffer_wr_addr), .buffer_wr_data(buffer_wr_data),
    .buffer_full(buffer_full), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (buffer_wr_valid) begin
      wr_cnt++;
      last_addr = buffer_wr_addr;
      last_data = buffer_wr_data;
      if (buffer_full) full_viol++;
    end
    if (noc_out_val && noc_out_rdy) begin
      ack_cnt++;
      last_ack = noc_out_data;
    end
  end
  typedef struct packed {
    logic [7:0] typ, len;
    logic [13:0] chip;
    logic [7:0] x, y, mshr, addr;
    logic [31:0] data;
    logic wr;
    logic [63:0] ack;
    logic [7:0] drop;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic send_flit(input logic [63:0] d);
    int n = 0;
    noc_in_val = 1;
    noc_in_data = d;
    while (!noc_in_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) chk("send_timeout", 64'(noc_in_rdy), 64'd1);
    @(posedge clk); #1;
    noc_in_val = 0;
  endtask
  task automatic send_req(input logic [7:0] typ, input logic [7:0] len, input logic [13:0] chip,
                          input logic [7:0] x, input logic [7:0] y, input logic [7:0] mshr,
                          input logic [7:0] addr, input logic [31:0] data);
    send_flit({14'd0, 8'd0, 8'd0, 4'd0, len, typ, mshr, 6'd0});
    if (typ == 8'd35 && len == 8'd2) begin
      send_flit({chip, x, y, 34'd0});
      send_flit({24'd0, addr, data});
    end else
      for (int i = 0; i < len; i++) send_flit(64'hFFFF_0000_FFFF_0000 ^ 64'(i));
  endtask
  initial begin
    int w0, a0, bad;
    logic [63:0] d0;
    tbl[0] = '{8'd35, 8'd2, 14'd0, 8'd1, 8'd2, 8'd5, 8'h01, 32'hDEADBEEF, 1'b1, 64'h0000_0408_0006_C140, 8'd0};
    tbl[1] = '{8'd35, 8'd2, 14'd3, 8'h10, 8'h20, 8'hAB, 8'h42, 32'h0BAD_F00D, 1'b1, 64'h000C_4080_0006_EAC0, 8'd0};
    tbl[2] = '{8'd14, 8'd3, 14'd0, 8'd0, 8'd0, 8'd7, 8'h00, 32'h0, 1'b0, 64'h0, 8'd1};
    tbl[3] = '{8'd35, 8'd2, 14'd0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 32'h0, 1'b1, 64'h0003_FC00_0006_FFC0, 8'd1};
    tbl[4] = '{8'd35, 8'd3, 14'd0, 8'd0, 8'd0, 8'd1, 8'h00, 32'h0, 1'b0, 64'h0, 8'd2};
    tbl[5] = '{8'd35, 8'd0, 14'd0, 8'd0, 8'd0, 8'd2, 8'h00, 32'h0, 1'b0, 64'h0, 8'd3};
    tbl[6] = '{8'd35, 8'd1, 14'd0, 8'd0, 8'd0, 8'd3, 8'h00, 32'h0, 1'b0, 64'h0, 8'd4};
    tbl[7] = '{8'd35, 8'd2, 14'h3FFF, 8'h00, 8'hFF, 8'h01, 8'h80, 32'h1234_5678, 1'b1, 64'hFFFC_03FC_0006_C040, 8'd4};
    #12;
    chk("rst_in_rdy", 64'(noc_in_rdy), 64'd1);
    chk("rst_out_val", 64'(noc_out_val), 64'd0);
    chk("rst_out_data", noc_out_data, 64'd0);
    chk("rst_wr_valid", 64'(buffer_wr_valid), 64'd0);
    chk("rst_wr_addr", 64'(buffer_wr_addr), 64'd0);
    chk("rst_wr_data", 64'(buffer_wr_data), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      w0 = wr_cnt;
      a0 = ack_cnt;
      send_req(tbl[i].typ, tbl[i].len, tbl[i].chip, tbl[i].x, tbl[i].y, tbl[i].mshr, tbl[i].addr, tbl[i].data);
      if (tbl[i].wr) begin
        chk("strobe_latency", 64'(buffer_wr_valid), 64'd1);
        chk("in_rdy_write", 64'(noc_in_rdy), 64'd0);
        @(posedge clk); #1;
        chk("ack_val", 64'(noc_out_val), 64'd1);
        chk("ack_data", noc_out_data, tbl[i].ack);
        @(posedge clk); #1;
        chk("ack_done", 64'(noc_out_val), 64'd0);
      end
      chk("back_in_hdr", 64'(noc_in_rdy), 64'd1);
      @(posedge clk); #1;
      chk("wr_count", 64'(wr_cnt - w0), 64'(tbl[i].wr));
      chk("ack_count", 64'(ack_cnt - a0), 64'(tbl[i].wr));
      chk("drop_count", 64'(drop_count), 64'(tbl[i].drop));
      if (tbl[i].wr) begin
        chk("wr_addr", 64'(last_addr), 64'(tbl[i].addr));
        chk("wr_data", 64'(last_data), 64'(tbl[i].data));
        chk("ack_flit", last_ack, tbl[i].ack);
      end
    end
    w0 = wr_cnt;
    a0 = ack_cnt;
    buffer_full = 1;
    send_req(8'd35, 8'd2, 14'd0, 8'd1, 8'd2, 8'd5, 8'h01, 32'hDEADBEEF);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (buffer_wr_valid || noc_in_rdy || noc_out_val) bad++;
      @(posedge clk); #1;
    end
    chk("full_hold", 64'(bad), 64'd0);
    chk("full_no_write", 64'(wr_cnt - w0), 64'd0);
    buffer_full = 0;
    #1;
    chk("full_release_strobe", 64'(buffer_wr_valid), 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("full_one_write", 64'(wr_cnt - w0), 64'd1);
    chk("full_one_ack", 64'(ack_cnt - a0), 64'd1);
    w0 = wr_cnt;
    a0 = ack_cnt;
    noc_out_rdy = 0;
    send_req(8'd35, 8'd2, 14'd0, 8'd9, 8'd8, 8'h33, 8'h11, 32'h5555_AAAA);
    @(posedge clk); #1;
    d0 = noc_out_data;
    chk("stall_ack_data", d0, 64'h0000_2420_0006_CCC0);
    noc_in_val = 1;
    noc_in_data = {14'd0, 8'd0, 8'd0, 4'd0, 8'd2, 8'd35, 8'h44, 6'd0};
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!noc_out_val || noc_out_data !== d0 || noc_in_rdy) bad++;
      @(posedge clk); #1;
    end
    chk("stall_hold", 64'(bad), 64'd0);
    chk("stall_no_ack", 64'(ack_cnt - a0), 64'd0);
    noc_out_rdy = 1;
    @(posedge clk); #1;
    chk("stall_ack_done", 64'(ack_cnt - a0), 64'd1);
    @(posedge clk); #1;
    noc_in_val = 0;
    send_flit({14'd0, 8'd3, 8'd4, 34'd0});
    send_flit({24'd0, 8'h22, 32'h0F0F_0F0F});
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("after_stall_writes", 64'(wr_cnt - w0), 64'd2);
    chk("after_stall_addr", 64'(last_addr), 64'h22);
    chk("after_stall_ack", last_ack, 64'h0000_0C10_0006_D100);
    bad = 0;
    noc_in_val = 1;
    noc_in_data = {14'd0, 8'd0, 8'd0, 4'd0, 8'd0, 8'd35, 8'd0, 6'd0};
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!noc_in_rdy) bad++;
      @(posedge clk); #1;
    end
    noc_in_val = 0;
    chk("sat_rdy", 64'(bad), 64'd0);
    chk("sat_drop", 64'(drop_count), 64'd255);
    w0 = wr_cnt;
    a0 = ack_cnt;
    buffer_full = 1;
    send_req(8'd35, 8'd2, 14'd0, 8'd1, 8'd1, 8'd9, 8'h5A, 32'hCAFE_F00D);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("arst_in_rdy", 64'(noc_in_rdy), 64'd1);
    chk("arst_out_val", 64'(noc_out_val), 64'd0);
    chk("arst_out_data", noc_out_data, 64'd0);
    chk("arst_wr_addr", 64'(buffer_wr_addr), 64'd0);
    chk("arst_wr_data", 64'(buffer_wr_data), 64'd0);
    chk("arst_drop", 64'(drop_count), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    buffer_full = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    chk("arst_no_write", 64'(wr_cnt - w0), 64'd0);
    chk("arst_no_ack", 64'(ack_cnt - a0), 64'd0);
    chk("arst_idle_rdy", 64'(noc_in_rdy), 64'd1);
    chk("never_write_full", 64'(full_viol), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
